// File: rtl/wave_pkg.sv
// Shared types and constants for the wave_bank oscillator bank.
package wave_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SAW    = 2'd1,
        SQUARE = 2'd2,
        TRI    = 2'd3
    } wave_mode_t;

    localparam int SAMPLE_W = 16;
    localparam int SCALE_SH = 15;
    localparam int PROD_W   = SAMPLE_W + 1;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] s;
        logic signed [SAMPLE_W-1:0] amp;
    } smp_t;

    // Raw waveform from the top 16 phase bits; triangle folds the upper half back down.
    function automatic logic [SAMPLE_W-1:0] wave_sample(input wave_mode_t mode,
                                                        input logic [SAMPLE_W-1:0] q);
        logic [SAMPLE_W-2:0] t;
        t = q[SAMPLE_W-1] ? ~q[SAMPLE_W-2:0] : q[SAMPLE_W-2:0];
        case (mode)
            SAW:     wave_sample = q ^ 16'h8000;
            SQUARE:  wave_sample = q[SAMPLE_W-1] ? 16'h8000 : 16'h7FFF;
            TRI:     wave_sample = {t, 1'b0} ^ 16'h8000;
            default: wave_sample = '0;
        endcase
    endfunction

endpackage

// File: rtl/wave_chan.sv
// One oscillator channel: shadow/active settings, phase accumulator,
// stage-1 waveform register and stage-2 scaled product.
module wave_chan
    import wave_pkg::*;
#(
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               sync,
    input  logic               commit,
    input  logic               we,
    input  logic [1:0]         cfg_mode,
    input  logic [15:0]        cfg_amp,
    input  logic [PHASE_W-1:0] cfg_off,
    input  logic [PHASE_W-1:0] cfg_pw,
    output logic [PROD_W-1:0]  v
);

    wave_mode_t          sh_mode, act_mode;
    logic [15:0]         sh_amp, act_amp;
    logic [PHASE_W-1:0]  sh_off, sh_pw, act_off, act_pw;
    logic [PHASE_W-1:0]  acc, p;
    smp_t                st1;
    logic signed [2*SAMPLE_W-1:0] prod;
    logic                unused_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_mode <= OFF;
            sh_amp  <= '0;
            sh_off  <= '0;
            sh_pw   <= '0;
        end else if (we) begin
            sh_mode <= wave_mode_t'(cfg_mode);
            sh_amp  <= cfg_amp;
            sh_off  <= cfg_off;
            sh_pw   <= cfg_pw;
        end
    end

    // Commit copies the pre-edge shadow, so a same-edge write waits for the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_mode <= OFF;
            act_amp  <= '0;
            act_off  <= '0;
            act_pw   <= '0;
        end else if (commit) begin
            act_mode <= sh_mode;
            act_amp  <= sh_amp;
            act_off  <= sh_off;
            act_pw   <= sh_pw;
        end
    end

    assign p = sync ? act_off : acc + act_off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            st1 <= '0;
        end else if (tick) begin
            acc     <= sync ? act_pw : acc + act_pw;
            st1.s   <= wave_sample(act_mode, p[PHASE_W-1 -: SAMPLE_W]);
            st1.amp <= act_amp;
        end
    end

    assign prod = $signed(st1.s) * $signed(st1.amp);

    // Arithmetic shift by taking the upper bits: floors toward minus infinity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) v <= '0;
        else        v <= prod[SCALE_SH +: PROD_W];
    end

    assign unused_bits = ^{prod[SCALE_SH-1:0], p};

endmodule

// File: rtl/wave_bank.sv
// N-channel additive oscillator bank with pipelined adder tree.
// Define WAVE_BANK_SAT_EN to clamp the sum to OUT_W bits instead of wrapping.
module wave_bank
    import wave_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int PHASE_W  = 24,
    parameter int OUT_W    = 16,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               sync,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [15:0]        cfg_amp,
    input  logic [PHASE_W-1:0] cfg_off,
    input  logic [PHASE_W-1:0] cfg_pw,
    output logic               out_valid,
    output logic [OUT_W-1:0]   results,
    output logic               sat
);

    localparam int SUM_W  = PROD_W + CH_W;
    localparam int STAGES = 2 + CH_W;
    localparam int NODES  = 2*CHANNELS - 1;

    logic                    pending, commit;
    logic [STAGES:0]         vld_pipe;
    logic [PROD_W-1:0]       v [CHANNELS];
    logic signed [SUM_W-1:0] node [NODES];
    logic signed [SUM_W-1:0] tn [CHANNELS-1];
    logic signed [SUM_W-1:0] root;
    logic [OUT_W-1:0]        sum_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      pending <= 1'b0;
        else if (cfg_we) pending <= 1'b1;
        else if (tick)   pending <= 1'b0;
    end

    assign commit = tick & pending;

    // vld_pipe[0] = stage 1, [1] = product, [1+L] = tree level L, [STAGES] = output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:0], tick};
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        wave_chan #(.PHASE_W(PHASE_W)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .sync     (sync),
            .commit   (commit),
            .we       (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_mode (cfg_mode),
            .cfg_amp  (cfg_amp),
            .cfg_off  (cfg_off),
            .cfg_pw   (cfg_pw),
            .v        (v[i])
        );
    end

    // Heap-ordered tree: node n has children 2n+1, 2n+2; leaves sit at the tail.
    always_comb begin
        for (int n = 0; n < CHANNELS-1; n++)
            node[n] = tn[n];
        for (int i = 0; i < CHANNELS; i++)
            node[CHANNELS-1+i] = {{CH_W{v[i][PROD_W-1]}}, v[i]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < CHANNELS-1; n++) tn[n] <= '0;
        end else begin
            for (int n = 0; n < CHANNELS-1; n++) tn[n] <= node[2*n+1] + node[2*n+2];
        end
    end

    assign root = node[0];

`ifdef WAVE_BANK_SAT_EN
    localparam logic signed [SUM_W-1:0] HI = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] LO = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic over, under;

    always_comb begin
        over   = root > HI;
        under  = root < LO;
        sum_nx = root[OUT_W-1:0];
        if (over)       sum_nx = HI[OUT_W-1:0];
        else if (under) sum_nx = LO[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sat <= 1'b0;
        else        sat <= vld_pipe[STAGES-1] & (over | under);
    end
`else
    assign sum_nx = root[OUT_W-1:0];
    assign sat    = 1'b0;

    if (SUM_W > OUT_W) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^root[SUM_W-1:OUT_W];
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  results <= '0;
        else if (vld_pipe[STAGES-1]) results <= sum_nx;
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_wave_bank.sv
// Directed bench for wave_bank at CHANNELS=4, PHASE_W=16, OUT_W=16.
module tb_wave_bank;
    localparam int CHANNELS = 4;
    localparam int PHASE_W  = 16;
    localparam int OUT_W    = 16;
    localparam int CH_W     = 2;
`ifdef WAVE_BANK_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset, tick, sync, cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [1:0]         cfg_mode;
    logic [15:0]        cfg_amp;
    logic [PHASE_W-1:0] cfg_off, cfg_pw;
    logic               out_valid, sat;
    logic [OUT_W-1:0]   results;

    int checks = 0;
    int errors = 0;
    int got_v[$];
    int got_i[$];
    int got_s[$];

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] amp;
        logic [15:0] off;
        int          exp_v;
        int          exp_sat;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    wave_bank #(.CHANNELS(CHANNELS), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_amp(cfg_amp),
        .cfg_off(cfg_off), .cfg_pw(cfg_pw),
        .out_valid(out_valid), .results(results), .sat(sat)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int ch, input logic [1:0] mode, input logic [15:0] amp,
                             input logic [15:0] off, input logic [15:0] pw);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = mode;
        cfg_amp = amp; cfg_off = off; cfg_pw = pw;
        cyc();
        cfg_we = 1'b0;
    endtask

    // smode: 0 no sync, 1 sync on first tick, 2 sync on every tick.
    // Records every out_valid with the index of the edge it followed.
    task automatic run_ticks(input int nt, input int smode);
        got_v.delete(); got_i.delete(); got_s.delete();
        for (int i = 0; i < nt + 10; i++) begin
            tick = (i < nt);
            sync = (i < nt) && (smode == 2 || (smode == 1 && i == 0));
            cyc();
            cfg_we = 1'b0;
            if (out_valid) begin
                got_v.push_back(int'($signed(results)));
                got_i.push_back(i);
                got_s.push_back(int'(sat));
            end
        end
        tick = 1'b0; sync = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int exp_seq[5];
        int ov_flag;
        vecs[0]  = '{2'd2, 16'h7FFF, 16'h0000,  32766, 0};
        vecs[1]  = '{2'd2, 16'h7FFF, 16'h8000, -32767, 0};
        vecs[2]  = '{2'd2, 16'h8000, 16'h0000, -32767, 0};
        vecs[3]  = '{2'd2, 16'h8000, 16'h8000, SAT_EN ? 32767 : -32768, SAT_EN ? 1 : 0};
        vecs[4]  = '{2'd1, 16'h7FFF, 16'h0000, -32767, 0};
        vecs[5]  = '{2'd1, 16'h7FFF, 16'h4000, -16384, 0};
        vecs[6]  = '{2'd1, 16'h0001, 16'h0000,     -1, 0};
        vecs[7]  = '{2'd1, 16'hFFFF, 16'h4000,      0, 0};
        vecs[8]  = '{2'd1, 16'h4000, 16'hC000,   8192, 0};
        vecs[9]  = '{2'd3, 16'h7FFF, 16'h0000, -32767, 0};
        vecs[10] = '{2'd3, 16'h7FFF, 16'h4000,      0, 0};
        vecs[11] = '{2'd3, 16'h7FFF, 16'h8000,  32765, 0};
        vecs[12] = '{2'd3, 16'h7FFF, 16'hC000,     -2, 0};
        vecs[13] = '{2'd0, 16'h7FFF, 16'h4000,      0, 0};

        reset = 1'b0; tick = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_amp = '0; cfg_off = '0; cfg_pw = '0;
        cyc(); cyc();
        chk("reset results", int'(results), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset sat", int'(sat), 0);
        reset = 1'b1;
        cyc();

        run_ticks(1, 0);
        chk("idle count", got_v.size(), 1);
        if (got_v.size() > 0) begin
            chk("idle value", got_v[0], 0);
            chk("idle latency", got_i[0], 4);
        end

        for (int k = 0; k < 14; k++) begin
            write_cfg(0, vecs[k].mode, vecs[k].amp, vecs[k].off, 16'h0000);
            run_ticks(1, 0);
            run_ticks(1, 2);
            chk($sformatf("vec%0d count", k), got_v.size(), 1);
            if (got_v.size() > 0) begin
                chk($sformatf("vec%0d results", k), got_v[0], vecs[k].exp_v);
                chk($sformatf("vec%0d sat", k), got_s[0], vecs[k].exp_sat);
                chk($sformatf("vec%0d latency", k), got_i[0], 4);
            end
        end

        // Back-to-back saw ticks, quarter-cycle phase steps
        exp_seq = '{-32767, -16384, 0, 16383, -32767};
        write_cfg(0, 2'd1, 16'h7FFF, 16'h0000, 16'h4000);
        run_ticks(1, 0);
        run_ticks(5, 1);
        chk("saw count", got_v.size(), 5);
        for (int k = 0; k < 5 && k < got_v.size(); k++) begin
            chk($sformatf("saw value %0d", k), got_v[k], exp_seq[k]);
            chk($sformatf("saw edge %0d", k), got_i[k], 4 + k);
        end

        // Without ticks, results must hold
        for (int k = 0; k < 4; k++) cyc();
        chk("hold results", int'($signed(results)), -32767);
        chk("hold out_valid", int'(out_valid), 0);

        // Write landing on a committing tick commits one tick later
        write_cfg(0, 2'd2, 16'h7FFF, 16'h0000, 16'h0000);
        run_ticks(1, 0);
        write_cfg(0, 2'd2, 16'h4000, 16'h0000, 16'h0000);
        cfg_we = 1'b1; cfg_ch = '0; cfg_mode = 2'd2; cfg_amp = 16'h2000;
        cfg_off = '0; cfg_pw = '0;
        run_ticks(3, 2);
        exp_seq = '{32766, 16383, 8191, 0, 0};
        chk("coincide count", got_v.size(), 3);
        for (int k = 0; k < 3 && k < got_v.size(); k++)
            chk($sformatf("coincide value %0d", k), got_v[k], exp_seq[k]);

        // All four channels at full-scale square
        for (int c = 0; c < 4; c++) write_cfg(c, 2'd2, 16'h7FFF, 16'h0000, 16'h0000);
        run_ticks(1, 0);
        run_ticks(1, 2);
        chk("overflow count", got_v.size(), 1);
        if (got_v.size() > 0) begin
            chk("overflow results", got_v[0], SAT_EN ? 32767 : -8);
            chk("overflow sat", got_s[0], SAT_EN ? 1 : 0);
        end

        // Reset in the middle of a tick stream
        tick = 1'b1; sync = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        reset = 1'b0;
        #1;
        chk("midreset results", int'(results), 0);
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset sat", int'(sat), 0);
        cyc(); cyc();
        reset = 1'b1; tick = 1'b0;
        ov_flag = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (out_valid) ov_flag = 1;
        end
        chk("post-reset quiet", ov_flag, 0);
        run_ticks(1, 0);
        chk("post-reset count", got_v.size(), 1);
        if (got_v.size() > 0) begin
            chk("post-reset latency", got_i[0], 4);
            chk("post-reset value", got_v[0], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
